fifo_param: RTL and testbench

FIFO_PARAM -- requirements
Module: fifo_param

---
 rtl/fifo_param.sv | 132 +++++++++++++
 tb/tb_fifo_param.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/fifo_param.sv
// Synchronous single-clock FIFO with registered read data, per-cycle ack/err status and optional
// almost-full/almost-empty thresholds (enabled by defining FIFO_THRESH_EN).
module fifo_param #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 3,
    parameter int AF_LEVEL = (1 << ADDR_W) - 1,
    parameter int AE_LEVEL = 1
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              wr_en,
    input  logic              rd_en,
    input  logic [DATA_W-1:0] d_in,
    output logic [DATA_W-1:0] d_out,
    output logic              full,
    output logic              empty,
    output logic              wr_ack,
    output logic              wr_err,
    output logic              rd_ack,
    output logic              rd_err,
    output logic [ADDR_W:0]   data_count,
    output logic              almost_full,
    output logic              almost_empty,
    output logic [2:0]        fsm_state
);

    localparam int DEPTH = 1 << ADDR_W;
    localparam logic [ADDR_W:0] DEPTH_C = DEPTH[ADDR_W:0];

    typedef enum logic [2:0] {
        INIT     = 3'd0,
        NO_OP    = 3'd1,
        WRITE    = 3'd2,
        WR_ERROR = 3'd3,
        READ     = 3'd4,
        RD_ERROR = 3'd5,
        WR_RD    = 3'd6
    } state_t;

    state_t            state;
    state_t            next_state;
    logic              do_wr;
    logic              do_rd;
    logic [ADDR_W-1:0] wr_ptr;
    logic [ADDR_W-1:0] rd_ptr;
    logic [ADDR_W:0]   cnt;
    logic [DATA_W-1:0] mem [DEPTH];

    // Handshake: wr_en/rd_en are requests sampled on every rising edge; the outcome of the
    // request is reported for exactly one cycle afterwards on *_ack (accepted) or *_err (refused).
    always_comb begin
        next_state = NO_OP;
        do_wr      = 1'b0;
        do_rd      = 1'b0;
        unique case ({wr_en, rd_en})
            2'b00: next_state = NO_OP;
            2'b10: begin
                next_state = full ? WR_ERROR : WRITE;
                do_wr      = !full;
            end
            2'b01: begin
                next_state = empty ? RD_ERROR : READ;
                do_rd      = !empty;
            end
            default: begin
                // Simultaneous request at a boundary silently drops the impossible half.
                if (empty) begin
                    next_state = WRITE;
                    do_wr      = 1'b1;
                end else if (full) begin
                    next_state = READ;
                    do_rd      = 1'b1;
                end else begin
                    next_state = WR_RD;
                    do_wr      = 1'b1;
                    do_rd      = 1'b1;
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state  <= INIT;
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
            d_out  <= '0;
        end else begin
            state <= next_state;
            if (do_wr) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_rd) begin
                d_out  <= mem[rd_ptr];
                rd_ptr <= rd_ptr + 1'b1;
            end
            unique case ({do_wr, do_rd})
                2'b10:   cnt <= cnt + 1'b1;
                2'b01:   cnt <= cnt - 1'b1;
                default: cnt <= cnt;
            endcase
        end
    end

    // Storage is intentionally left unreset; the pointers alone define what is valid.
    always_ff @(posedge clk) begin
        if (do_wr) begin
            mem[wr_ptr] <= d_in;
        end
    end

    assign full       = (cnt == DEPTH_C);
    assign empty      = (cnt == '0);
    assign data_count = cnt;
    assign wr_ack     = (state == WRITE) || (state == WR_RD);
    assign rd_ack     = (state == READ) || (state == WR_RD);
    assign wr_err     = (state == WR_ERROR);
    assign rd_err     = (state == RD_ERROR);
    assign fsm_state  = state;

`ifdef FIFO_THRESH_EN
    localparam logic [ADDR_W:0] AF_C = AF_LEVEL[ADDR_W:0];
    localparam logic [ADDR_W:0] AE_C = AE_LEVEL[ADDR_W:0];
    assign almost_full  = (cnt >= AF_C);
    assign almost_empty = (cnt <= AE_C);
`else
    assign almost_full  = 1'b0;
    assign almost_empty = 1'b0;
`endif

endmodule

// File: tb/tb_fifo_param.sv
// Directed bench for fifo_param (ADDR_W=3, DATA_W=32): fill/overflow, drain/underflow,
// simultaneous read/write, boundary collisions, pointer wrap and mid-burst reset.
module tb_fifo_param;

    logic        clk;
    logic        reset_n;
    logic        wr_en;
    logic        rd_en;
    logic [31:0] d_in;
    logic [31:0] d_out;
    logic        full;
    logic        empty;
    logic        wr_ack;
    logic        wr_err;
    logic        rd_ack;
    logic        rd_err;
    logic [3:0]  data_count;
    logic        almost_full;
    logic        almost_empty;
    logic [2:0]  fsm_state;

    int total = 0;
    int bad   = 0;
    int exp_cnt = 0;
    logic [31:0] exp_q[$];
    logic [31:0] exp_d = 32'h0;

    fifo_param #(.DATA_W(32), .ADDR_W(3)) dut (
        .clk(clk), .reset_n(reset_n), .wr_en(wr_en), .rd_en(rd_en), .d_in(d_in),
        .d_out(d_out), .full(full), .empty(empty), .wr_ack(wr_ack), .wr_err(wr_err),
        .rd_ack(rd_ack), .rd_err(rd_err), .data_count(data_count),
        .almost_full(almost_full), .almost_empty(almost_empty), .fsm_state(fsm_state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Level flags derived from the bench's own count model.
    task automatic chk_levels(input string tag);
        logic exp_af;
        logic exp_ae;
`ifdef FIFO_THRESH_EN
        exp_af = (exp_cnt >= 7);
        exp_ae = (exp_cnt <= 1);
`else
        exp_af = 1'b0;
        exp_ae = 1'b0;
`endif
        chk({tag, ".count"}, 32'(data_count), 32'(exp_cnt));
        chk({tag, ".full"},  32'(full),  32'(exp_cnt == 8));
        chk({tag, ".empty"}, 32'(empty), 32'(exp_cnt == 0));
        chk({tag, ".af"},    32'(almost_full),  32'(exp_af));
        chk({tag, ".ae"},    32'(almost_empty), 32'(exp_ae));
    endtask

    task automatic step(input logic w, input logic r, input logic [31:0] d);
        wr_en = w;
        rd_en = r;
        d_in  = d;
        @(posedge clk);
        #1;
        wr_en = 1'b0;
        rd_en = 1'b0;
    endtask

    // Write expected to succeed.
    task automatic wr_ok(input string tag, input logic [31:0] d);
        step(1'b1, 1'b0, d);
        exp_q.push_back(d);
        exp_cnt++;
        chk({tag, ".wr_ack"}, 32'(wr_ack), 32'd1);
        chk({tag, ".wr_err"}, 32'(wr_err), 32'd0);
        chk_levels(tag);
    endtask

    // Read expected to succeed; data comes from the scoreboard queue.
    task automatic rd_ok(input string tag);
        step(1'b0, 1'b1, 32'h0);
        exp_d = exp_q.pop_front();
        exp_cnt--;
        chk({tag, ".rd_ack"}, 32'(rd_ack), 32'd1);
        chk({tag, ".rd_err"}, 32'(rd_err), 32'd0);
        chk({tag, ".d_out"},  d_out, exp_d);
        chk_levels(tag);
    endtask

    initial begin
        reset_n = 1'b0;
        wr_en   = 1'b0;
        rd_en   = 1'b0;
        d_in    = 32'h0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst.state", 32'(fsm_state), 32'd0);
        chk("rst.d_out", d_out, 32'h0);
        chk("rst.acks", {28'h0, wr_ack, wr_err, rd_ack, rd_err}, 32'h0);
`ifdef FIFO_THRESH_EN
        chk("rst.ae", 32'(almost_empty), 32'd1);
`endif
        chk_levels("rst");
        @(negedge clk);
        reset_n = 1'b1;

        // Idle cycle leaves INIT with no flags.
        step(1'b0, 1'b0, 32'h0);
        chk("idle.acks", {28'h0, wr_ack, wr_err, rd_ack, rd_err}, 32'h0);
        chk("idle.state", 32'(fsm_state), 32'd1);

        // Fill with 1..8, then overflow attempt.
        for (int i = 1; i <= 8; i++) wr_ok("fill", 32'(i));
        step(1'b1, 1'b0, 32'hdead_beef);
        chk("ovf.wr_err", 32'(wr_err), 32'd1);
        chk("ovf.wr_ack", 32'(wr_ack), 32'd0);
        chk_levels("ovf");

        // Drain in order, then underflow attempt keeps d_out.
        for (int i = 1; i <= 8; i++) rd_ok("drain");
        step(1'b0, 1'b1, 32'h0);
        chk("udf.rd_err", 32'(rd_err), 32'd1);
        chk("udf.rd_ack", 32'(rd_ack), 32'd0);
        chk("udf.d_out", d_out, 32'h8);
        chk_levels("udf");

        // Simultaneous read/write at count 3.
        for (int i = 0; i < 3; i++) wr_ok("pre3", 32'h10 + 32'(i));
        for (int i = 0; i < 4; i++) begin
            step(1'b1, 1'b1, 32'h20 + 32'(i));
            exp_q.push_back(32'h20 + 32'(i));
            exp_d = exp_q.pop_front();
            chk("wrrd.wr_ack", 32'(wr_ack), 32'd1);
            chk("wrrd.rd_ack", 32'(rd_ack), 32'd1);
            chk("wrrd.d_out", d_out, exp_d);
            chk_levels("wrrd");
        end
        for (int i = 0; i < 3; i++) rd_ok("post3");

        // Both requests at empty: only the write happens.
        step(1'b1, 1'b1, 32'h30);
        exp_q.push_back(32'h30);
        exp_cnt++;
        chk("bothE.wr_ack", 32'(wr_ack), 32'd1);
        chk("bothE.rd_ack", 32'(rd_ack), 32'd0);
        chk("bothE.rd_err", 32'(rd_err), 32'd0);
        chk_levels("bothE");
        for (int i = 1; i < 8; i++) wr_ok("fill2", 32'h30 + 32'(i));

        // Both requests at full: only the read happens, 0x99 is dropped.
        step(1'b1, 1'b1, 32'h99);
        exp_d = exp_q.pop_front();
        exp_cnt--;
        chk("bothF.rd_ack", 32'(rd_ack), 32'd1);
        chk("bothF.wr_ack", 32'(wr_ack), 32'd0);
        chk("bothF.wr_err", 32'(wr_err), 32'd0);
        chk("bothF.d_out", d_out, exp_d);
        chk_levels("bothF");
        for (int i = 0; i < 7; i++) rd_ok("drain2");

        // Pointer wrap with write/read pairs.
        for (int i = 0; i < 12; i++) begin
            wr_ok("wrapw", 32'h100 + 32'(i));
            rd_ok("wrapr");
        end

        // Reset in the middle of a burst at count 5.
        for (int i = 0; i < 5; i++) wr_ok("burst", 32'h200 + 32'(i));
        wr_en = 1'b1;
        d_in  = 32'h2ff;
        #2;
        reset_n = 1'b0;
        #1;
        exp_q.delete();
        exp_cnt = 0;
        chk("midrst.state", 32'(fsm_state), 32'd0);
        chk("midrst.d_out", d_out, 32'h0);
        chk("midrst.acks", {28'h0, wr_ack, wr_err, rd_ack, rd_err}, 32'h0);
        chk_levels("midrst");
        wr_en = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        step(1'b0, 1'b1, 32'h0);
        chk("postrst.rd_err", 32'(rd_err), 32'd1);
        chk("postrst.rd_ack", 32'(rd_ack), 32'd0);
        chk_levels("postrst");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
